// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction memory handshake plus the decode/execute side.
// master = fetch unit, slave = memory and consumer environment.
interface fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] pc_plus2;
  logic        done;
  logic        br;
  logic        br_reg;
  logic [2:0]  br_ccc;
  logic [15:0] br_imm;
  logic [15:0] br_rs;
  logic        flag_n;
  logic        flag_z;
  logic        flag_v;
  logic        halt;
  logic        halted;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc_plus2, halted,
    input  imem_rdata, imem_valid, done, br, br_reg, br_ccc, br_imm, br_rs,
           flag_n, flag_z, flag_v, halt
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc_plus2, halted,
    output imem_rdata, imem_valid, done, br, br_reg, br_ccc, br_imm, br_rs,
           flag_n, flag_z, flag_v, halt
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, fetches one instruction at a time from a variable-latency
// memory, holds it for decode until done, then steps or branches the PC (2 cycles/instr minimum).
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_ISSUE, S_HALTED} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] seq_pc, br_pc, next_pc;
  logic        cond, taken;
  logic        req, ivld, hlt;

  assign seq_pc = pc_q + PC_STEP;
  assign br_pc  = seq_pc + {bus.br_imm[14:0], 1'b0};

  always_comb begin
    cond = 1'b1;
    case (bus.br_ccc)
      3'b000:  cond = !bus.flag_z;
      3'b001:  cond = bus.flag_z;
      3'b010:  cond = !bus.flag_z && !bus.flag_n;
      3'b011:  cond = bus.flag_n;
      3'b100:  cond = bus.flag_z || !bus.flag_n;
      3'b101:  cond = bus.flag_n || bus.flag_z;
      3'b110:  cond = bus.flag_v;
      default: cond = 1'b1;
    endcase
  end

  // br_reg wins if decode ever raises both branch kinds
  assign taken   = (bus.br || bus.br_reg) && cond;
  assign next_pc = !taken     ? seq_pc :
                   bus.br_reg ? bus.br_rs : br_pc;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    req     = 1'b0;
    ivld    = 1'b0;
    hlt     = 1'b0;
    unique case (state_q)
      S_FETCH, S_WAIT: begin
        req = 1'b1;
        if (bus.imem_valid) begin
          instr_d = bus.imem_rdata;
          state_d = S_ISSUE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_ISSUE: begin
        ivld = 1'b1;
        if (bus.done) begin
          if (bus.halt) begin
            state_d = S_HALTED;
          end else begin
            pc_d    = next_pc;
            state_d = S_FETCH;
          end
        end
      end
      S_HALTED: hlt = 1'b1;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // The reset state is FETCH, so the request is masked while reset is held
  assign bus.imem_req    = req && rst;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = ivld;
  assign bus.pc_plus2    = seq_pc;
  assign bus.halted      = hlt;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: acts as instruction memory and consumer, tracks the expected PC.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [15:0] exp_pc;
  logic [15:0] word;

  fetch_unit_if bus ();

  fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] ref_next(input logic [15:0] pc, input logic b, input logic r,
                                          input logic [2:0] ccc, input logic [15:0] imm,
                                          input logic [15:0] rs, input logic n, input logic z,
                                          input logic v);
    logic c;
    int   t;
    case (ccc)
      3'd0: c = !z;
      3'd1: c = z;
      3'd2: c = !z && !n;
      3'd3: c = n;
      3'd4: c = z || (!z && !n);
      3'd5: c = n || z;
      3'd6: c = v;
      default: c = 1'b1;
    endcase
    if ((b || r) && c) begin
      if (r) return rs;
      t = int'(pc) + 2 + 2 * int'($signed(imm));
      return 16'(t & 32'hFFFF);
    end
    t = int'(pc) + 2;
    return 16'(t & 32'hFFFF);
  endfunction

  task automatic clear_ctl();
    bus.done = 0; bus.halt = 0; bus.br = 0; bus.br_reg = 0; bus.br_ccc = 0;
    bus.br_imm = 0; bus.br_rs = 0; bus.flag_n = 0; bus.flag_z = 0; bus.flag_v = 0;
  endtask

  // Serve one fetch with lat idle cycles; done pulses during the wait must be ignored.
  task automatic fetch_one(input int lat);
    int guard = 0;
    while (!bus.imem_req && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("req_seen", 32'(bus.imem_req), 32'd1);
    chk("addr", 32'(bus.imem_addr), 32'(exp_pc));
    chk("pc_plus2", 32'(bus.pc_plus2), 32'(16'(exp_pc + 16'd2)));
    word = 16'($urandom);
    for (int i = 0; i < lat; i++) begin
      bus.done = 1'($urandom_range(0, 1));
      bus.halt = 1'($urandom_range(0, 1));
      bus.br_reg = 1; bus.br_ccc = 3'b111; bus.br_rs = 16'($urandom);
      @(negedge clk);
      chk("req_hold", 32'(bus.imem_req), 32'd1);
      chk("addr_hold", 32'(bus.imem_addr), 32'(exp_pc));
      chk("iv_low_wait", 32'(bus.instr_valid), 32'd0);
    end
    clear_ctl();
    bus.imem_valid = 1; bus.imem_rdata = word;
    @(negedge clk);
    bus.imem_valid = 0; bus.imem_rdata = 16'($urandom);
    chk("iv_rise", 32'(bus.instr_valid), 32'd1);
    chk("instr", 32'(bus.instr), 32'(word));
  endtask

  // Hold the instruction for dly cycles (stray memory strobes dropped), then complete it.
  task automatic consume(input int dly, input logic b, input logic r, input logic h,
                         input logic [2:0] ccc, input logic [15:0] imm, input logic [15:0] rs,
                         input logic n, input logic z, input logic v);
    for (int i = 0; i < dly; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        bus.imem_valid = 1; bus.imem_rdata = ~word;
      end
      @(negedge clk);
      bus.imem_valid = 0;
      chk("iv_hold", 32'(bus.instr_valid), 32'd1);
      chk("instr_hold", 32'(bus.instr), 32'(word));
    end
    bus.done = 1; bus.br = b; bus.br_reg = r; bus.halt = h; bus.br_ccc = ccc;
    bus.br_imm = imm; bus.br_rs = rs; bus.flag_n = n; bus.flag_z = z; bus.flag_v = v;
    @(negedge clk);
    clear_ctl();
    if (h) begin
      chk("halted", 32'(bus.halted), 32'd1);
    end else begin
      chk("iv_drop", 32'(bus.instr_valid), 32'd0);
      exp_pc = ref_next(exp_pc, b, r, ccc, imm, rs, n, z, v);
    end
  endtask

  task automatic jump(input logic [15:0] tgt);
    fetch_one(0);
    consume(0, 0, 1, 0, 3'b111, 16'h0, tgt, 0, 0, 0);
  endtask

  initial begin
    bus.imem_valid = 0; bus.imem_rdata = 0;
    clear_ctl();
    exp_pc = 16'h0000;
    #1;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_iv", 32'(bus.instr_valid), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_instr", 32'(bus.instr), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);

    // Zero-wait sequential stream
    for (int i = 0; i < 3; i++) begin
      fetch_one(0);
      consume(0, 0, 0, 0, 3'b000, 16'h0, 16'h0, 0, 0, 0);
    end
    chk("seq_pc", 32'(exp_pc), 32'h6);
    fetch_one(3);
    consume(2, 0, 0, 0, 3'b000, 16'h0, 16'h0, 0, 0, 0);

    // B EQ with imm=-3 taken, then not taken
    jump(16'h0010);
    fetch_one(0);
    consume(0, 1, 0, 0, 3'b001, 16'hFFFD, 16'h0, 0, 1, 0);
    chk("b_eq_taken", 32'(exp_pc), 32'h000C);
    jump(16'h0010);
    fetch_one(1);
    consume(1, 1, 0, 0, 3'b001, 16'hFFFD, 16'h0, 0, 0, 0);
    chk("b_eq_not", 32'(exp_pc), 32'h0012);

    // BR always, then BR OV with V clear
    fetch_one(0);
    consume(0, 0, 1, 0, 3'b111, 16'h0, 16'h1234, 0, 0, 0);
    chk("br_always", 32'(exp_pc), 32'h1234);
    fetch_one(0);
    consume(0, 0, 1, 0, 3'b110, 16'h0, 16'h5678, 0, 0, 0);
    chk("br_ov_not", 32'(exp_pc), 32'h1236);

    // PC wrap at the top of the address space
    jump(16'hFFFE);
    fetch_one(0);
    consume(0, 0, 0, 0, 3'b000, 16'h0, 16'h0, 0, 0, 0);
    chk("wrap", 32'(exp_pc), 32'h0000);

    // Randomized instruction mix
    for (int i = 0; i < 80; i++) begin
      logic b, r;
      int   k = $urandom_range(0, 3);
      b = (k == 1) || (k == 3);
      r = (k == 2) || (k == 3 && $urandom_range(0, 1) == 1);
      fetch_one($urandom_range(0, 3));
      consume($urandom_range(0, 2), b, r, 0, 3'($urandom), 16'($urandom_range(0, 64)) - 16'd32,
              16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Halt, stays halted, then reset restarts at RESET_PC
    jump(16'h0020);
    fetch_one(2);
    consume(1, 0, 0, 1, 3'b000, 16'h0, 16'h0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      bus.imem_valid = 1; bus.done = 1; bus.br_reg = 1; bus.br_ccc = 3'b111; bus.br_rs = 16'h4444;
      @(negedge clk);
      chk("hlt_stay", 32'(bus.halted), 32'd1);
      chk("hlt_req", 32'(bus.imem_req), 32'd0);
      chk("hlt_iv", 32'(bus.instr_valid), 32'd0);
      chk("hlt_pc", 32'(bus.imem_addr), 32'h0020);
    end
    bus.imem_valid = 0; clear_ctl();
    rst = 0;
    #1;
    chk("hlt_rst_halted", 32'(bus.halted), 32'd0);
    @(negedge clk);
    rst = 1;
    exp_pc = 16'h0000;
    @(negedge clk);
    fetch_one(0);
    consume(0, 0, 0, 0, 3'b000, 16'h0, 16'h0, 0, 0, 0);

    // Reset while a request is outstanding; the response arrives during reset
    jump(16'h0300);
    chk("wait_addr", 32'(bus.imem_addr), 32'h0300);
    @(negedge clk);
    @(negedge clk);
    chk("wait_req", 32'(bus.imem_req), 32'd1);
    #2;
    rst = 0;
    #1;
    chk("arst_req", 32'(bus.imem_req), 32'd0);
    chk("arst_addr", 32'(bus.imem_addr), 32'h0000);
    chk("arst_iv", 32'(bus.instr_valid), 32'd0);
    @(negedge clk);
    bus.imem_valid = 1; bus.imem_rdata = 16'hDEAD;
    @(negedge clk);
    bus.imem_valid = 0;
    chk("arst_drop_iv", 32'(bus.instr_valid), 32'd0);
    rst = 1;
    exp_pc = 16'h0000;
    @(negedge clk);
    chk("post_rst_iv", 32'(bus.instr_valid), 32'd0);
    fetch_one(1);
    consume(0, 0, 0, 0, 3'b000, 16'h0, 16'h0, 0, 0, 0);
    chk("post_rst_pc", 32'(exp_pc), 32'h0002);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
